// File: rtl/matrix_stream_parser_if.sv
// Byte-stream in / matrix-element out bundle for matrix_stream_parser.
// The slave side is the parser; the master side is the source plus sink.
interface matrix_stream_parser_if #(
  parameter int MAX_ELEMENT_SIZE = 8,
  parameter int MAX_SIZE_A       = 32,
  parameter int MAX_SIZE_B       = 32
);
  localparam int RW = $clog2(MAX_SIZE_A);
  localparam int CW = $clog2(MAX_SIZE_B);

  logic [MAX_ELEMENT_SIZE-1:0] byte_in;
  logic                        byte_valid;
  logic                        byte_ready;
  logic                        out_ready;
  logic                        valid_data_in_o;
  logic [RW-1:0]               row_addr;
  logic [CW-1:0]               col_addr;
  logic [MAX_ELEMENT_SIZE-1:0] matrix_element;
  logic                        last_element;
  logic                        frame_done;
  logic                        hdr_error;

  modport master (
    output byte_in, byte_valid, out_ready,
    input  byte_ready, valid_data_in_o, row_addr, col_addr,
           matrix_element, last_element, frame_done, hdr_error
  );

  modport slave (
    input  byte_in, byte_valid, out_ready,
    output byte_ready, valid_data_in_o, row_addr, col_addr,
           matrix_element, last_element, frame_done, hdr_error
  );
endinterface

// File: rtl/matrix_stream_parser.sv
// Parses A5 / R-1 / C-1 / row-major data frames into addressed matrix elements
// through a single skid-free output register.
module matrix_stream_parser #(
  parameter int MAX_ELEMENT_SIZE = 8,
  parameter int MAX_SIZE_A       = 32,
  parameter int MAX_SIZE_B       = 32
) (
  input  logic                   inter_refclk,
  input  logic                   rst_n,
  matrix_stream_parser_if.slave  bus
);
  localparam int W  = MAX_ELEMENT_SIZE;
  localparam int RW = $clog2(MAX_SIZE_A);
  localparam int CW = $clog2(MAX_SIZE_B);
  localparam logic [W-1:0] SYNC_BYTE = W'(8'hA5);

  typedef enum logic [2:0] {SYNC, HDR_R, HDR_C, DATA, ERR} state_t;

  state_t        state;
  logic          armed;
  logic [W-1:0]  rows_m1, cols_m1;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [W-1:0]  elem_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          vld_q, last_q, err_q;
  logic          rdy, acc, handoff, col_end, is_last;

  // Header bounds are checked against the full byte; counters compare zero-extended.
  assign col_end = (W'(col) == cols_m1);
  assign is_last = col_end && (W'(row) == rows_m1);
  assign acc     = bus.byte_valid && rdy;
  assign handoff = vld_q && bus.out_ready;

  // armed holds byte_ready low until the first edge after reset release.
  always_comb begin
    rdy = 1'b0;
    unique case (state)
      SYNC, HDR_R, HDR_C: rdy = armed;
      DATA:               rdy = armed && (!vld_q || bus.out_ready);
      default:            rdy = 1'b0;
    endcase
  end

  always_ff @(posedge inter_refclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SYNC;
      armed   <= 1'b0;
      rows_m1 <= '0;
      cols_m1 <= '0;
      row     <= '0;
      col     <= '0;
      elem_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      armed <= 1'b1;
      err_q <= 1'b0;
      if (handoff) vld_q <= 1'b0;
      unique case (state)
        SYNC: if (acc && bus.byte_in == SYNC_BYTE) state <= HDR_R;
        HDR_R: if (acc) begin
          rows_m1 <= bus.byte_in;
          if (int'(bus.byte_in) >= MAX_SIZE_A) begin
            state <= ERR;
            err_q <= 1'b1;
          end else begin
            state <= HDR_C;
          end
        end
        HDR_C: if (acc) begin
          cols_m1 <= bus.byte_in;
          if (int'(bus.byte_in) >= MAX_SIZE_B) begin
            state <= ERR;
            err_q <= 1'b1;
          end else begin
            row   <= '0;
            col   <= '0;
            state <= DATA;
          end
        end
        DATA: if (acc) begin
          // A load in the handoff cycle overrides the valid clear above.
          elem_q <= bus.byte_in;
          row_q  <= row;
          col_q  <= col;
          vld_q  <= 1'b1;
          last_q <= is_last;
          if (col_end) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
          if (is_last) state <= SYNC;
        end
        ERR:     state <= SYNC;
        default: state <= SYNC;
      endcase
    end
  end

  assign bus.byte_ready      = rdy;
  assign bus.valid_data_in_o = vld_q;
  assign bus.row_addr        = row_q;
  assign bus.col_addr        = col_q;
  assign bus.matrix_element  = elem_q;
  assign bus.last_element    = last_q;
  assign bus.frame_done      = handoff && last_q;
  assign bus.hdr_error       = err_q;
endmodule

// File: tb/tb_matrix_stream_parser.sv
// Scoreboard bench for matrix_stream_parser: the driver pushes the expected
// element for each accepted data byte, the monitor pops on every handoff.
module tb_matrix_stream_parser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_stream_parser_if bif();
  matrix_stream_parser dut (.inter_refclk(clk), .rst_n(rst_n), .bus(bif));

  typedef struct packed {
    logic [4:0]  row;
    logic [4:0]  col;
    logic [7:0]  elem;
    logic        last;
    logic [31:0] acc;
  } exp_t;

  exp_t sb[$];
  exp_t it;
  int   ho_t[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, fd_cnt = 0, err_cnt = 0, fd0;
  logic err_rdy = 1'b1, fd_sync = 1'b0, chk_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: sample between edges.
  always @(negedge clk) if (rst_n) begin
    if (bif.valid_data_in_o && bif.out_ready) begin
      if (sb.size() == 0) chk("unexpected_elem", 1, 0);
      else begin
        it = sb.pop_front();
        chk("row",  32'(bif.row_addr), 32'(it.row));
        chk("col",  32'(bif.col_addr), 32'(it.col));
        chk("elem", 32'(bif.matrix_element), 32'(it.elem));
        chk("last", 32'(bif.last_element), 32'(it.last));
        chk("fdone", 32'(bif.frame_done), 32'(it.last));
        // visible in the cycle right after the byte's accepting edge
        if (chk_lat) chk("latency", cyc, it.acc);
        ho_t.push_back(cyc);
      end
    end else if (bif.frame_done) chk("fd_spurious", 1, 0);
    if (bif.frame_done) begin
      fd_cnt++;
      fd_sync |= bif.byte_valid && bif.byte_ready && (bif.byte_in == 8'hA5);
    end
    if (bif.hdr_error) begin
      err_cnt++;
      err_rdy = bif.byte_ready;
    end
  end

  // Called aligned at posedge+1; returns with the byte accepted, again at posedge+1.
  task automatic send_byte(input logic [7:0] b, output int a);
    int   n = 0;
    logic got = 1'b0;
    bif.byte_in    = b;
    bif.byte_valid = 1'b1;
    a = -1;
    while (!got) begin
      @(negedge clk); got = bif.byte_ready;
      @(posedge clk); #1;
      n++;
      if (!got && n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    if (got) a = cyc;
    bif.byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int r, input int c, input logic [7:0] base, input int nmax);
    int   a;
    exp_t e;
    send_byte(8'hA5, a);
    send_byte(8'(r - 1), a);
    send_byte(8'(c - 1), a);
    for (int i = 0; i < r * c && i < nmax; i++) begin
      send_byte(base + 8'(i), a);
      e.row  = 5'(i / c);
      e.col  = 5'(i % c);
      e.elem = base + 8'(i);
      e.last = (i == r * c - 1);
      e.acc  = 32'(a);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bif.valid_data_in_o) && n < 100) begin
      @(negedge clk); n++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(bif.valid_data_in_o), 0);
    chk({tag, "_elem"},  32'(bif.matrix_element), 0);
    chk({tag, "_row"},   32'(bif.row_addr), 0);
    chk({tag, "_col"},   32'(bif.col_addr), 0);
    chk({tag, "_last"},  32'(bif.last_element), 0);
    chk({tag, "_fd"},    32'(bif.frame_done), 0);
    chk({tag, "_err"},   32'(bif.hdr_error), 0);
    chk({tag, "_rdy"},   32'(bif.byte_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int a;
    bif.byte_in    = '0;
    bif.byte_valid = 1'b0;
    bif.out_ready  = 1'b1;
    #3;
    chk_outputs_zero("reset");
    @(posedge clk); #1; rst_n = 1'b1; #1;
    chk("rdy_at_release", 32'(bif.byte_ready), 0);
    @(posedge clk); #1;
    chk("rdy_after_edge", 32'(bif.byte_ready), 1);

    // 2x3 frame, continuous flow
    chk_lat = 1'b1; fd0 = fd_cnt;
    send_frame(2, 3, 8'h10, 99);
    drain();
    chk("fd_2x3", fd_cnt - fd0, 1);

    // noise before sync, then 1x1
    fd0 = fd_cnt;
    send_byte(8'h00, a); send_byte(8'h33, a);
    send_frame(1, 1, 8'h7E, 99);
    drain();
    chk("fd_1x1", fd_cnt - fd0, 1);

    // header rejects at both bounds, then recovery
    fd0 = fd_cnt;
    send_byte(8'hA5, a); send_byte(8'h20, a);
    send_frame(1, 1, 8'h55, 99);
    drain();
    chk("err_rows_cnt", err_cnt, 1);
    chk("err_rows_rdy", 32'(err_rdy), 0);
    err_rdy = 1'b1;
    send_byte(8'hA5, a); send_byte(8'h00, a); send_byte(8'h20, a);
    send_frame(1, 1, 8'h56, 99);
    drain();
    chk("err_cols_cnt", err_cnt, 2);
    chk("err_cols_rdy", 32'(err_rdy), 0);
    chk("fd_after_err", fd_cnt - fd0, 2);

    // largest legal row count
    send_frame(32, 1, 8'h80, 99);
    drain();

    // output stall for 5 cycles after first element
    chk_lat = 1'b0; fd0 = fd_cnt;
    bif.out_ready = 1'b0;
    fork
      send_frame(2, 2, 8'h40, 99);
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (!bif.valid_data_in_o && n < 50);
        chk("stall_seen", 32'(bif.valid_data_in_o), 1);
        for (int i = 0; i < 5; i++) begin
          chk("stall_elem", 32'(bif.matrix_element), 32'h40);
          chk("stall_rc", {bif.row_addr, bif.col_addr}, 0);
          chk("stall_rdy", 32'(bif.byte_ready), 0);
          if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        bif.out_ready = 1'b1;
      end
    join
    drain();
    chk("fd_stall", fd_cnt - fd0, 1);

    // reset mid-frame after 3 of 6 elements
    send_frame(2, 3, 8'h20, 3);
    #1 rst_n = 1'b0; #1;
    chk_outputs_zero("midrst");
    sb.delete();
    fd0 = fd_cnt;
    @(posedge clk); #1; rst_n = 1'b1; #1;
    chk("midrst_rdy_release", 32'(bif.byte_ready), 0);
    @(posedge clk); #1;
    chk("fd_midrst_none", fd_cnt - fd0, 0);
    send_frame(1, 2, 8'hAA, 99);
    drain();
    chk("fd_after_rst", fd_cnt - fd0, 1);

    // back-to-back frames
    chk_lat = 1'b1; fd_sync = 1'b0; fd0 = fd_cnt;
    ho_t.delete();
    send_frame(2, 2, 8'h60, 99);
    send_frame(2, 2, 8'h70, 99);
    drain();
    chk("b2b_fd", fd_cnt - fd0, 2);
    chk("b2b_fd_with_sync", 32'(fd_sync), 1);
    chk("b2b_count", ho_t.size(), 8);
    if (ho_t.size() == 8) begin
      chk("b2b_frame1_span", ho_t[3] - ho_t[0], 3);
      chk("b2b_gap", ho_t[4] - ho_t[3], 4);
      chk("b2b_total_span", ho_t[7] - ho_t[0], 10);
    end

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_stream_parser.md
MATRIX_STREAM_PARSER -- requirements
Module: matrix_stream_parser

Interface
REQ-001 Parameter MAX_ELEMENT_SIZE, default 8: element and input byte width in bits.
REQ-002 Parameter MAX_SIZE_A, default 32: maximum matrix row count.
REQ-003 Parameter MAX_SIZE_B, default 32: maximum matrix column count.
REQ-004 Port inter_refclk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port byte_in, input, MAX_ELEMENT_SIZE: inbound stream byte.
REQ-007 Port byte_valid, input, 1: byte_in is valid this cycle.
REQ-008 Port byte_ready, output, 1: the parser accepts byte_in this cycle.
REQ-009 Port out_ready, input, 1: the downstream compiler accepts the output element.
REQ-010 Port valid_data_in_o, output, 1: an output element is valid.
REQ-011 Port row_addr, output, $clog2(MAX_SIZE_A): row index of the output element.
REQ-012 Port col_addr, output, $clog2(MAX_SIZE_B): column index of the output element.
REQ-013 Port matrix_element, output, MAX_ELEMENT_SIZE: element value.
REQ-014 Port last_element, output, 1: the output element is the final element of the frame.
REQ-015 Port frame_done, output, 1: one-cycle pulse when the final element is handed off.
REQ-016 Port hdr_error, output, 1: one-cycle pulse when a header is rejected.

Function
REQ-017 A byte transfers only when byte_valid && byte_ready in the same cycle; an output element transfers only when valid_data_in_o && out_ready.
REQ-018 Frame format, in order: sync byte 0xA5, then R-1, then C-1, then R*C element bytes in row-major order (col fastest).
REQ-019 The state machine has five states: SYNC, HDR_R, HDR_C, DATA, ERR.
REQ-020 SYNC: byte_ready=1; an accepted 0xA5 moves to HDR_R; any other accepted byte is discarded and the state remains SYNC.
REQ-021 HDR_R: byte_ready=1; an accepted byte is latched as rows_m1.
  - If rows_m1 >= MAX_SIZE_A, move to ERR.
  - Otherwise move to HDR_C.
REQ-022 HDR_C: byte_ready=1; an accepted byte is latched as cols_m1.
  - If cols_m1 >= MAX_SIZE_B, move to ERR.
  - Otherwise clear the row and column counters to 0 and move to DATA.
REQ-023 ERR lasts exactly one cycle: byte_ready=0, hdr_error=1, then move to SYNC.
REQ-024 DATA: byte_ready = !valid_data_in_o || out_ready (single output register, no bubble under continuous flow).
REQ-025 In DATA, an accepted byte loads the output register on the next edge (1-cycle latency):
  - matrix_element=byte, row_addr=row counter, col_addr=col counter, valid_data_in_o=1.
  - last_element=(row==rows_m1 && col==cols_m1).
REQ-026 Counter update on each accepted element:
  - If col==cols_m1: col->0, row->row+1.
  - Else: col->col+1.
REQ-027 Accepting the final element (last_element condition) moves the FSM to SYNC; no further bytes are accepted for that frame.
REQ-028 The output register holds its values stable while valid_data_in_o && !out_ready.
REQ-029 On a handoff with no new byte loaded in the same cycle, valid_data_in_o clears on the next edge.
REQ-030 frame_done=1 in exactly the cycle where valid_data_in_o && out_ready && last_element.
REQ-031 A pending last element may be handed off while the FSM is already in SYNC and accepting the next frame's sync byte; both events are legal in the same cycle.
REQ-032 A 1x1 frame (R-1=0, C-1=0) yields one element with row=0, col=0, last_element=1.
REQ-033 Counters use only the widths of row_addr and col_addr; header comparisons use the full MAX_ELEMENT_SIZE-bit byte.

Reset
REQ-034 While rst_n=0, all state is cleared immediately, independent of the clock:
  - FSM=SYNC; counters, rows_m1, cols_m1, matrix_element, row_addr, col_addr = 0.
  - valid_data_in_o, last_element, frame_done, hdr_error = 0.
REQ-035 byte_ready=0 while rst_n=0; it becomes 1 on the first edge after rst_n rises.
REQ-036 Reset asserted mid-frame discards the partial frame; no frame_done is produced for it.

Verification
REQ-037 Stream A5,01,02,then 10..15, out_ready=1 ->
  - six elements (0,0)=10h, (0,1)=11h, (0,2)=12h, (1,0)=13h, (1,1)=14h, (1,2)=15h, each 1 cycle after its byte;
  - last_element and frame_done on 15h only.
REQ-038 Bytes 00,33,A5,00,00,7E ->
  - 00 and 33 discarded;
  - single element (0,0)=7Eh with last_element=1 and frame_done=1.
REQ-039 A5,20 with MAX_SIZE_A=32 -> hdr_error pulses for 1 cycle and byte_ready=0 that cycle; a following A5,00,00,55 is parsed normally.
REQ-040 2x2 frame with out_ready held 0 for 5 cycles after the first element ->
  - element (0,0) held stable;
  - byte_ready=0 throughout;
  - no element lost or duplicated after out_ready=1.
REQ-041 rst_n pulled low after 3 of 6 elements of a 2x3 frame ->
  - all outputs 0 immediately;
  - after release, a new A5,00,01,AA,BB yields (0,0)=AAh, (0,1)=BBh, frame_done once.
REQ-042 Back-to-back frames with a continuously valid stream ->
  - frame N's last element handed off in the same cycle frame N+1's A5 is accepted;
  - total throughput is one element per cycle in DATA.
